// File: rtl/apple1_pia_io_if.sv
// Apple-1 PIA bus, keyboard and display signal bundle.
// The slave side is the register block; the master side drives CPU and peripherals.
interface apple1_pia_io_if;
    logic        cpu_clken;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        cs;
    logic        flush;
    logic        kbd_valid;
    logic [6:0]  kbd_data;
    logic        kbd_ready;
    logic        kbd_ovf;
    logic        dsp_valid;
    logic [6:0]  dsp_data;
    logic        dsp_ready;

    modport master (
        output cpu_clken, addr, we, din, flush,
        output kbd_valid, kbd_data, dsp_ready,
        input  dout, cs, kbd_ready, kbd_ovf,
        input  dsp_valid, dsp_data
    );

    modport slave (
        input  cpu_clken, addr, we, din, flush,
        input  kbd_valid, kbd_data, dsp_ready,
        output dout, cs, kbd_ready, kbd_ovf,
        output dsp_valid, dsp_data
    );
endinterface

// File: rtl/apple1_pia_io.sv
// Apple-1 PIA register window (KBD/KBDCR/DSP/DSPCR)
// with keyboard and display FIFOs.
module apple1_pia_io #(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          KBD_DEPTH = 8,
    parameter int          DSP_DEPTH = 4
) (
    input logic           clk7,
    input logic           rst_n,
    apple1_pia_io_if.slave bus
);
    localparam int KAW = $clog2(KBD_DEPTH);
    localparam int DAW = $clog2(DSP_DEPTH);
    localparam logic [KAW:0]   KFULL = (KAW+1)'(KBD_DEPTH);
    localparam logic [DAW:0]   DFULL = (DAW+1)'(DSP_DEPTH);
    localparam logic [KAW:0]   KC1   = 1;
    localparam logic [DAW:0]   DC1   = 1;
    localparam logic [KAW-1:0] KP1   = 1;
    localparam logic [DAW-1:0] DP1   = 1;

    logic [6:0]     kbd_mem [KBD_DEPTH];
    logic [KAW-1:0] kbd_wp, kbd_rp;
    logic [KAW:0]   kbd_cnt;
    logic           kbd_ovf_q;
    logic [6:0]     last_key;
    logic [6:0]     dsp_mem [DSP_DEPTH];
    logic [DAW-1:0] dsp_wp, dsp_rp;
    logic [DAW:0]   dsp_cnt;
    logic [7:0]     dout_q, rd_data;

    logic       acc, rd, wr;
    logic [1:0] off;
    logic       kbd_empty, kbd_full, kbd_push, kbd_pop;
    logic       ovf_set, ovf_clr;
    logic       dsp_empty, dsp_full, dsp_push, dsp_pop;
    logic [6:0] kbd_head;
    logic       unused_din7;

    assign bus.cs = bus.addr[15:2] == BASE_ADDR[15:2];
    assign acc    = bus.cs & bus.cpu_clken;
    assign rd     = acc & ~bus.we;
    assign wr     = acc & bus.we;
    assign off    = bus.addr[1:0];

    assign kbd_empty = kbd_cnt == '0;
    assign kbd_full  = kbd_cnt == KFULL;
    assign kbd_head  = kbd_mem[kbd_rp];
    assign kbd_push  = bus.kbd_valid & ~kbd_full;
    assign kbd_pop   = rd & (off == 2'd0) & ~kbd_empty;
    assign ovf_set   = bus.kbd_valid & kbd_full;
    assign ovf_clr   = rd & (off == 2'd1);

    // A pop frees the head slot this edge, so a full FIFO may still accept.
    assign dsp_empty = dsp_cnt == '0;
    assign dsp_full  = dsp_cnt == DFULL;
    assign dsp_pop   = ~dsp_empty & bus.dsp_ready;
    assign dsp_push  = wr & (off == 2'd2) & (~dsp_full | dsp_pop);

    assign bus.kbd_ready = ~kbd_full;
    assign bus.kbd_ovf   = kbd_ovf_q;
    assign bus.dsp_valid = ~dsp_empty;
    assign bus.dsp_data  = dsp_empty ? 7'h00 : dsp_mem[dsp_rp];
    assign bus.dout      = dout_q;
    assign unused_din7   = bus.din[7];

    always_comb begin
        rd_data = 8'h00;
        unique case (off)
            2'd0:    rd_data = {1'b1, kbd_empty ? last_key : kbd_head};
            2'd1:    rd_data = {~kbd_empty, kbd_ovf_q, 6'b0};
            2'd2:    rd_data = {dsp_full, 7'b0};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= 8'h00;
            last_key <= 7'h00;
        end else begin
            if (rd) dout_q <= rd_data;
            if (kbd_pop & ~bus.flush) last_key <= kbd_head;
        end
    end

    always_ff @(posedge clk7) begin
        if (kbd_push & ~bus.flush) kbd_mem[kbd_wp] <= bus.kbd_data;
        if (dsp_push & ~bus.flush) dsp_mem[dsp_wp] <= bus.din[6:0];
    end

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            kbd_wp    <= '0;
            kbd_rp    <= '0;
            kbd_cnt   <= '0;
            kbd_ovf_q <= 1'b0;
        end else if (bus.flush) begin
            kbd_wp    <= '0;
            kbd_rp    <= '0;
            kbd_cnt   <= '0;
            kbd_ovf_q <= 1'b0;
        end else begin
            if (kbd_push) kbd_wp <= kbd_wp + KP1;
            if (kbd_pop)  kbd_rp <= kbd_rp + KP1;
            unique case ({kbd_push, kbd_pop})
                2'b10:   kbd_cnt <= kbd_cnt + KC1;
                2'b01:   kbd_cnt <= kbd_cnt - KC1;
                default: kbd_cnt <= kbd_cnt;
            endcase
            if (ovf_set)      kbd_ovf_q <= 1'b1;
            else if (ovf_clr) kbd_ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            dsp_wp  <= '0;
            dsp_rp  <= '0;
            dsp_cnt <= '0;
        end else if (bus.flush) begin
            dsp_wp  <= '0;
            dsp_rp  <= '0;
            dsp_cnt <= '0;
        end else begin
            if (dsp_push) dsp_wp <= dsp_wp + DP1;
            if (dsp_pop)  dsp_rp <= dsp_rp + DP1;
            unique case ({dsp_push, dsp_pop})
                2'b10:   dsp_cnt <= dsp_cnt + DC1;
                2'b01:   dsp_cnt <= dsp_cnt - DC1;
                default: dsp_cnt <= dsp_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_apple1_pia_io.sv
// Bench for apple1_pia_io: queue-based reference model checked every
// cycle, directed register scenarios pinned with literals, then random traffic.
module tb_apple1_pia_io;
    localparam logic [15:0] BASE = 16'hD010;
    localparam int KD = 8;
    localparam int DD = 4;

    logic clk7  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk7 = ~clk7;

    apple1_pia_io_if bus ();

    apple1_pia_io #(
        .BASE_ADDR (BASE),
        .KBD_DEPTH (KD),
        .DSP_DEPTH (DD)
    ) dut (
        .clk7  (clk7),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] kq[$];
    logic [6:0] dq[$];
    logic [6:0] last_m;
    logic       ovf_m;
    logic [7:0] dout_m;

    bit         pin_dout_en, pin_flag_en, pin_dd_en;
    logic [7:0] pin_dout;
    logic       pin_rdy, pin_vld, pin_ovf;
    logic [6:0] pin_dd;
    string      pin_name;

    task automatic model_reset();
        kq.delete();
        dq.delete();
        last_m = 7'h00;
        ovf_m  = 1'b0;
        dout_m = 8'h00;
    endtask

    task automatic model_step();
        bit acc, rd, wr, kpop, kclr, kpush, kset, dpop, dpush;
        logic [1:0] off;
        acc  = (bus.addr[15:2] == BASE[15:2]) && bus.cpu_clken;
        off  = bus.addr[1:0];
        rd   = acc && !bus.we;
        wr   = acc && bus.we;
        kpop = 0;
        kclr = 0;
        if (rd) begin
            case (off)
                2'd0: begin
                    if (kq.size() > 0) begin
                        dout_m = {1'b1, kq[0]};
                        kpop = 1;
                    end else begin
                        dout_m = {1'b1, last_m};
                    end
                end
                2'd1: begin
                    dout_m = {(kq.size() != 0), ovf_m, 6'b0};
                    kclr = 1;
                end
                2'd2: dout_m = {(dq.size() == DD), 7'b0};
                default: dout_m = 8'h00;
            endcase
        end
        kpush = bus.kbd_valid && (kq.size() < KD);
        kset  = bus.kbd_valid && (kq.size() == KD);
        dpop  = (dq.size() > 0) && bus.dsp_ready;
        dpush = wr && (off == 2'd2) && ((dq.size() < DD) || dpop);
        if (bus.flush) begin
            kq.delete();
            dq.delete();
            ovf_m = 1'b0;
        end else begin
            if (kpop)  last_m = kq.pop_front();
            if (kpush) kq.push_back(bus.kbd_data);
            if (dpop)  void'(dq.pop_front());
            if (dpush) dq.push_back(bus.din[6:0]);
            if (kset)      ovf_m = 1'b1;
            else if (kclr) ovf_m = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk7) begin
        chk("cs", {7'b0, bus.cs}, {7'b0, bus.addr[15:2] == BASE[15:2]});
        chk("dout", bus.dout, dout_m);
        chk("kbd_ready", {7'b0, bus.kbd_ready}, {7'b0, kq.size() < KD});
        chk("kbd_ovf", {7'b0, bus.kbd_ovf}, {7'b0, ovf_m});
        chk("dsp_valid", {7'b0, bus.dsp_valid}, {7'b0, dq.size() != 0});
        if (dq.size() != 0)
            chk("dsp_data", {1'b0, bus.dsp_data}, {1'b0, dq[0]});
        if (pin_dout_en)
            chk({"pin_", pin_name}, bus.dout, pin_dout);
        if (pin_flag_en) begin
            chk("pin_kbd_ready", {7'b0, bus.kbd_ready}, {7'b0, pin_rdy});
            chk("pin_dsp_valid", {7'b0, bus.dsp_valid}, {7'b0, pin_vld});
            chk("pin_kbd_ovf", {7'b0, bus.kbd_ovf}, {7'b0, pin_ovf});
        end
        if (pin_dd_en)
            chk("pin_dsp_data", {1'b0, bus.dsp_data}, {1'b0, pin_dd});
    end

    task automatic idle();
        bus.cpu_clken = 1'b0;
        bus.addr      = 16'h0000;
        bus.we        = 1'b0;
        bus.din       = 8'h00;
        bus.flush     = 1'b0;
        bus.kbd_valid = 1'b0;
        bus.kbd_data  = 7'h00;
        bus.dsp_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk7);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        pin_dout_en = 0;
        pin_flag_en = 0;
        pin_dd_en   = 0;
    endtask

    task automatic pin_flags(input logic r, input logic v, input logic o);
        pin_flag_en = 1;
        pin_rdy = r;
        pin_vld = v;
        pin_ovf = o;
    endtask

    task automatic pin_head(input logic [6:0] d);
        pin_dd_en = 1;
        pin_dd = d;
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] exp,
                      input string nm);
        bus.addr      = BASE + 16'(off);
        bus.we        = 1'b0;
        bus.cpu_clken = 1'b1;
        step();
        bus.cpu_clken = 1'b0;
        bus.addr      = 16'h0000;
        pin_dout_en = 1;
        pin_dout    = exp;
        pin_name    = nm;
    endtask

    task automatic wr_dsp(input logic [6:0] c);
        bus.addr      = BASE + 16'd2;
        bus.we        = 1'b1;
        bus.din       = {1'b0, c};
        bus.cpu_clken = 1'b1;
        step();
        bus.cpu_clken = 1'b0;
        bus.we        = 1'b0;
        bus.addr      = 16'h0000;
    endtask

    task automatic key(input logic [6:0] c);
        bus.kbd_valid = 1'b1;
        bus.kbd_data  = c;
        step();
        bus.kbd_valid = 1'b0;
    endtask

    int kprob[4] = '{3, 1, 2, 0};
    int dprob[4] = '{0, 3, 1, 2};

    initial begin
        idle();
        model_reset();
        step();
        pin_flags(1, 0, 0);
        pin_head(7'h00);
        pin_dout_en = 1;
        pin_dout    = 8'h00;
        pin_name    = "reset_dout";
        step();
        rst_n = 1'b1;
        rd(2'd1, 8'h00, "reset_kbdcr");
        rd(2'd2, 8'h00, "reset_dsp");

        key(7'h41);
        key(7'h42);
        rd(2'd1, 8'h80, "kbdcr_two");
        rd(2'd0, 8'hC1, "kbd_A");
        rd(2'd0, 8'hC2, "kbd_B");
        rd(2'd1, 8'h00, "kbdcr_empty");
        rd(2'd0, 8'hC2, "kbd_lastkey");

        for (int i = 0; i < 9; i++) begin
            key(7'(8'h30 + i));
            if (i == 7) pin_flags(0, 0, 0);
            if (i == 8) pin_flags(0, 0, 1);
        end
        rd(2'd1, 8'hC0, "kbdcr_ovf");
        rd(2'd1, 8'h80, "kbdcr_ovf_clr");
        for (int i = 0; i < 8; i++)
            rd(2'd0, 8'(8'hB0 + i), "kbd_drain");
        rd(2'd1, 8'h00, "kbdcr_drained");

        for (int i = 0; i < 4; i++) wr_dsp(7'(8'h50 + i));
        rd(2'd2, 8'h80, "dsp_full");
        wr_dsp(7'h54);
        pin_head(7'h50);
        pin_flags(1, 1, 0);
        bus.dsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) pin_head(7'(8'h51 + i));
        end
        bus.dsp_ready = 1'b0;
        pin_flags(1, 0, 0);
        rd(2'd2, 8'h00, "dsp_empty");

        for (int i = 0; i < 4; i++) wr_dsp(7'(8'h60 + i));
        bus.dsp_ready = 1'b1;
        wr_dsp(7'h64);
        bus.dsp_ready = 1'b0;
        pin_head(7'h61);
        rd(2'd2, 8'h80, "dsp_full_pushpop");
        bus.dsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) pin_head(7'(8'h62 + i));
        end
        bus.dsp_ready = 1'b0;
        pin_flags(1, 0, 0);

        for (int i = 0; i < 9; i++) key(7'(8'h20 + i));
        pin_flags(0, 0, 1);
        bus.flush     = 1'b1;
        bus.kbd_valid = 1'b1;
        bus.kbd_data  = 7'h7F;
        step();
        bus.flush     = 1'b0;
        bus.kbd_valid = 1'b0;
        pin_flags(1, 0, 0);
        rd(2'd1, 8'h00, "kbdcr_flush");
        rd(2'd0, 8'hB7, "kbd_flush_lastkey");

        key(7'h11);
        key(7'h12);
        wr_dsp(7'h13);
        bus.kbd_valid = 1'b1;
        bus.kbd_data  = 7'h14;
        rst_n = 1'b0;
        model_reset();
        pin_flags(1, 0, 0);
        pin_head(7'h00);
        pin_dout_en = 1;
        pin_dout    = 8'h00;
        pin_name    = "midrst_dout";
        step();
        bus.kbd_valid = 1'b0;
        step();
        rst_n = 1'b1;
        rd(2'd1, 8'h00, "midrst_kbdcr");
        rd(2'd0, 8'h80, "midrst_kbd");
        rd(2'd2, 8'h00, "midrst_dsp");

        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 250) % 4;
            bus.cpu_clken = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.addr = 16'($urandom);
            else bus.addr = BASE + 16'($urandom_range(0, 3));
            bus.we        = ($urandom_range(0, 2) == 0);
            bus.din       = 8'($urandom);
            bus.kbd_data  = 7'($urandom);
            bus.kbd_valid = ($urandom_range(0, 3) < kprob[ph]);
            bus.dsp_ready = ($urandom_range(0, 3) < dprob[ph]);
            bus.flush     = ($urandom_range(0, 149) == 0);
            if (bus.flush) bus.cpu_clken = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
